counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//   Sequences the period/slope counter through a programmable table of up to DEPTH
//   segments: drives the counter's enable, period and slope. Uses the counter's
//   end-of-period pulse to step between segments without a gap. Sits between the
//   register/config interface and a single counter instance; optional looping.
// PARAMETERS
//   DEPTH  4  number of table entries (power of 2, >=2); AW = $clog2(DEPTH)
//   PW     8  period width, matches counter period port
//   RW     8  repeat-count width; entry runs (repeat+1) periods
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous, active-low reset
//   cfg_we      in   1       table write strobe
//   cfg_addr    in   AW      table write index
//   cfg_period  in   PW      entry period
//   cfg_slope   in   1       entry slope
//   cfg_repeat  in   RW      entry repeat count
//   cfg_last    in   1       entry terminates the sequence
//   start       in   1       begin sequence at entry 0 (honoured only in IDLE)
//   stop        in   1       abort sequence
//   loop        in   1       sampled at end of last entry: 1 = restart at entry 0
//   cnt_wrap    in   1       one-cycle pulse from counter at end of each period
//   cnt_enable  out  1       counter enable
//   cnt_period  out  PW      counter period
//   cnt_slope   out  1       counter slope
//   busy        out  1       high in LOAD/RUN
//   done        out  1       one-cycle pulse on natural sequence completion
//   cur_index   out  AW      index of entry currently driven
// BEHAVIOUR
//   - All state updates on posedge clk. reset==0: table entries all-zero (last=0),
//     state IDLE, cnt_enable=0, cnt_period=0, cnt_slope=0, busy=0, done=0,
//     cur_index=0, remaining count=0. Reset mid-sequence aborts immediately.
//   - Table write: cfg_we=1 writes {period,slope,repeat,last} at cfg_addr, any state.
//     Entry fields sampled at load time; same-cycle write+load of one address -> old value.
//   - FSM IDLE: cnt_enable=0, period/slope outputs hold. start=1 -> LOAD, cur_index=0.
//   - LOAD (1 cycle): cnt_period/cnt_slope <= entry[cur_index], rem <= repeat,
//     cnt_enable=0, busy=1; -> RUN. start->first enabled cycle latency = 2 clocks.
//   - RUN: cnt_enable=1. On cnt_wrap:
//       rem!=0 -> rem-1, outputs unchanged.
//       rem==0, entry not last and cur_index!=DEPTH-1 -> cur_index+1, load that entry's
//         period/slope/repeat at this same edge; cnt_enable stays 1 (no gap).
//       rem==0, entry last or cur_index==DEPTH-1: loop=1 -> cur_index=0, load entry 0
//         same edge, enable stays 1; loop=0 -> IDLE, cnt_enable=0, done=1 for 1 cycle.
//     cnt_wrap ignored outside RUN.
//   - stop=1 in LOAD/RUN -> IDLE next edge, cnt_enable=0, done stays 0; stop beats
//     cnt_wrap in same cycle. stop in IDLE no effect. start+stop in IDLE: stop wins.
//   - start while busy ignored. cur_index wraps only via loop, never by overflow.
//   - repeat=0 entry runs exactly one period; period value passed through, not checked.
// TESTING
//   1 reset=0 3 clk -> all outputs 0; release, no start -> cnt_enable stays 0.
//   2 entry0={0x0A,1,rep 1,last 0}, entry1={0xBD,0,rep 0,last 1}, start -> enable high
//     2 clk later, period 0x0A slope 1; 2 wraps -> period 0xBD slope 0 same edge,
//     enable never drops; 1 more wrap -> enable 0, done 1 clk, busy 0.
//   3 as 2 with loop=1 -> after entry1 wrap, period 0x0A, cur_index 0, enable held.
//   4 all 4 entries last=0 -> after entry3 completes, sequence ends (loop=0), done pulses.
//   5 stop asserted same cycle as cnt_wrap in RUN -> IDLE, period unchanged, done 0.
//   6 reset=0 mid-RUN -> next edge all outputs 0, table cleared; start again -> period 0.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// Bundle of configuration, control and counter-facing signals for counter_sequencer.
// master drives the table/control inputs and the counter wrap pulse; slave is the sequencer.
interface counter_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int PW    = 8,
  parameter int RW    = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [PW-1:0] cfg_period;
  logic          cfg_slope;
  logic [RW-1:0] cfg_repeat;
  logic          cfg_last;
  logic          start;
  logic          stop;
  logic          loop;
  logic          cnt_wrap;
  logic          cnt_enable;
  logic [PW-1:0] cnt_period;
  logic          cnt_slope;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_index;

  modport master (
    output cfg_we, cfg_addr, cfg_period, cfg_slope, cfg_repeat, cfg_last,
    output start, stop, loop, cnt_wrap,
    input  cnt_enable, cnt_period, cnt_slope, busy, done, cur_index
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_period, cfg_slope, cfg_repeat, cfg_last,
    input  start, stop, loop, cnt_wrap,
    output cnt_enable, cnt_period, cnt_slope, busy, done, cur_index
  );
endinterface

// File: rtl/counter_sequencer.sv
// Steps a period/slope counter through a small programmable segment table.
// Each entry runs (repeat+1) counter periods; the next entry is loaded on the
// same edge as the final wrap so the counter never sees an enable gap.
module counter_sequencer #(
  parameter int DEPTH = 4,
  parameter int PW    = 8,
  parameter int RW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_sequencer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_load = 2'd1,
    s_run  = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;

  // segment table, cleared by reset so a fresh start after reset sees zeros
  logic [PW-1:0] tbl_period_reg [DEPTH];
  logic          tbl_slope_reg  [DEPTH];
  logic [RW-1:0] tbl_repeat_reg [DEPTH];
  logic          tbl_last_reg   [DEPTH];

  logic [PW-1:0] cnt_period_reg;
  logic          cnt_slope_reg;
  logic [RW-1:0] rem_reg;
  logic          cur_last_reg;
  logic [AW-1:0] cur_index_reg;
  logic          done_reg;

  // datapath control decoded from state and inputs
  logic          load_en;
  logic [AW-1:0] load_idx;
  logic          rem_dec;
  logic          idx_clear;
  logic          done_set;
  logic          end_of_seq;

  // the running entry is the final one if flagged last or at the top of the table
  assign end_of_seq = cur_last_reg || (cur_index_reg == AW'(DEPTH - 1));

  // per-entry table write; a load in the same cycle reads the pre-write value
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
      always_ff @(posedge clk) begin
        if (!reset) begin
          tbl_period_reg[gi] <= '0;
          tbl_slope_reg[gi]  <= 1'b0;
          tbl_repeat_reg[gi] <= '0;
          tbl_last_reg[gi]   <= 1'b0;
        end else if (bus.cfg_we && (bus.cfg_addr == AW'(gi))) begin
          tbl_period_reg[gi] <= bus.cfg_period;
          tbl_slope_reg[gi]  <= bus.cfg_slope;
          tbl_repeat_reg[gi] <= bus.cfg_repeat;
          tbl_last_reg[gi]   <= bus.cfg_last;
        end
      end
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= s_idle;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state; stop dominates both start and wrap
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      s_idle: if (bus.start && !bus.stop) state_next = s_load;
      s_load: state_next = bus.stop ? s_idle : s_run;
      s_run: begin
        if (bus.stop) begin
          state_next = s_idle;
        end else if (bus.cnt_wrap && (rem_reg == '0) && end_of_seq && !bus.loop) begin
          state_next = s_idle;
        end
      end
      default: state_next = s_idle;
    endcase
  end

  // FSM outputs: enable only while running, busy across load and run
  always_comb begin
    bus.cnt_enable = (state_reg == s_run);
    bus.busy       = (state_reg != s_idle);
  end

  // datapath control: what to load, count or flag on this edge
  always_comb begin
    load_en   = 1'b0;
    load_idx  = cur_index_reg;
    rem_dec   = 1'b0;
    idx_clear = 1'b0;
    done_set  = 1'b0;
    case (state_reg)
      s_idle: idx_clear = bus.start && !bus.stop;
      s_load: load_en = !bus.stop;
      s_run: begin
        if (!bus.stop && bus.cnt_wrap) begin
          if (rem_reg != '0) begin
            rem_dec = 1'b1;
          end else if (!end_of_seq) begin
            load_en  = 1'b1;
            load_idx = cur_index_reg + AW'(1);
          end else if (bus.loop) begin
            load_en  = 1'b1;
            load_idx = '0;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // datapath registers: current entry fields, remaining count, done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_period_reg <= '0;
      cnt_slope_reg  <= 1'b0;
      rem_reg        <= '0;
      cur_last_reg   <= 1'b0;
      cur_index_reg  <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= done_set;
      if (idx_clear) begin
        cur_index_reg <= '0;
      end
      if (load_en) begin
        cur_index_reg  <= load_idx;
        cnt_period_reg <= tbl_period_reg[load_idx];
        cnt_slope_reg  <= tbl_slope_reg[load_idx];
        rem_reg        <= tbl_repeat_reg[load_idx];
        cur_last_reg   <= tbl_last_reg[load_idx];
      end else if (rem_dec) begin
        rem_reg <= rem_reg - RW'(1);
      end
    end
  end

  assign bus.cnt_period = cnt_period_reg;
  assign bus.cnt_slope  = cnt_slope_reg;
  assign bus.done       = done_reg;
  assign bus.cur_index  = cur_index_reg;
endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: stimulus side advances a segment-level
// reference model and queues the expected outputs; a monitor compares each cycle.
module tb_counter_sequencer;
  localparam int DEPTH = 4;
  localparam int PW    = 8;
  localparam int RW    = 8;

  typedef struct packed {
    logic       en;
    logic [7:0] per;
    logic       sl;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  counter_sequencer_if #(.DEPTH(DEPTH), .PW(PW), .RW(RW)) bus ();

  counter_sequencer #(.DEPTH(DEPTH), .PW(PW), .RW(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: table contents plus "which segment, how many periods left"
  int   m_per [DEPTH];
  int   m_sl  [DEPTH];
  int   m_rep [DEPTH];
  int   m_lst [DEPTH];
  int   m_mode;        // 0 idle, 1 waiting to load first segment, 2 running
  int   m_idx;
  int   m_left;        // periods still to run in the current segment
  int   m_last;
  int   m_out_per;
  int   m_out_sl;
  int   m_done;

  task automatic enter(input int i);
    m_idx     = i;
    m_out_per = m_per[i];
    m_out_sl  = m_sl[i];
    m_left    = m_rep[i] + 1;
    m_last    = m_lst[i];
  endtask

  task automatic model_cycle();
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_per[i] = 0; m_sl[i] = 0; m_rep[i] = 0; m_lst[i] = 0;
      end
      m_mode = 0; m_idx = 0; m_left = 0; m_last = 0;
      m_out_per = 0; m_out_sl = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        if (bus.start && !bus.stop) begin
          m_mode = 1;
          m_idx  = 0;
        end
      end else if (m_mode == 1) begin
        if (bus.stop) m_mode = 0;
        else begin
          enter(m_idx);
          m_mode = 2;
        end
      end else begin
        if (bus.stop) m_mode = 0;
        else if (bus.cnt_wrap) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_last == 0 && m_idx != DEPTH - 1) enter(m_idx + 1);
            else if (bus.loop) enter(0);
            else begin
              m_mode = 0;
              m_done = 1;
            end
          end
        end
      end
      if (bus.cfg_we) begin
        m_per[bus.cfg_addr] = bus.cfg_period;
        m_sl[bus.cfg_addr]  = bus.cfg_slope;
        m_rep[bus.cfg_addr] = bus.cfg_repeat;
        m_lst[bus.cfg_addr] = bus.cfg_last;
      end
    end
  endtask

  task automatic clear_pulses();
    bus.cfg_we   = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.cnt_wrap = 1'b0;
  endtask

  // one clock: model sees the inputs the DUT will sample at the coming edge
  task automatic step();
    exp_t e;
    model_cycle();
    e.en   = (m_mode == 2);
    e.per  = 8'(m_out_per);
    e.sl   = 1'(m_out_sl);
    e.busy = (m_mode != 0);
    e.done = 1'(m_done);
    e.idx  = 2'(m_idx);
    sb.push_back(e);
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input int p, input int s, input int r, input int l);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 2'(a);
    bus.cfg_period = 8'(p);
    bus.cfg_slope  = 1'(s);
    bus.cfg_repeat = 8'(r);
    bus.cfg_last   = 1'(l);
    step();
  endtask

  task automatic wraps(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      idle(gap);
      bus.cnt_wrap = 1'b1;
      step();
    end
  endtask

  task automatic go();
    bus.start = 1'b1;
    step();
  endtask

  // monitor: one comparison per clock against the head of the scoreboard
  initial begin
    exp_t e;
    exp_t got;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      got = {bus.cnt_enable, bus.cnt_period, bus.cnt_slope, bus.busy, bus.done, bus.cur_index};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow t=%0t got=%h", $time, got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL cycle t=%0t got en=%b per=%h sl=%b busy=%b done=%b idx=%0d exp en=%b per=%h sl=%b busy=%b done=%b idx=%0d",
                   $time, got.en, got.per, got.sl, got.busy, got.done, got.idx,
                   e.en, e.per, e.sl, e.busy, e.done, e.idx);
        end else begin
          $display("ok t=%0t en=%b per=%h sl=%b busy=%b done=%b idx=%0d",
                   $time, got.en, got.per, got.sl, got.busy, got.done, got.idx);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_pulses();
    bus.loop       = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_period = '0;
    bus.cfg_slope  = 1'b0;
    bus.cfg_repeat = '0;
    bus.cfg_last   = 1'b0;
    @(negedge clk);

    // reset held, then released with no start
    idle(3);
    reset = 1'b1;
    idle(3);

    // two-entry sequence, no loop
    wr(0, 8'h0A, 1, 1, 0);
    wr(1, 8'hBD, 0, 0, 1);
    go();
    idle(2);
    wraps(3, 1);
    idle(2);

    // same table with loop, then stop
    bus.loop = 1'b1;
    go();
    idle(1);
    wraps(4, 0);
    bus.stop = 1'b1;
    step();
    bus.loop = 1'b0;
    idle(2);

    // full table without last flags runs off the top entry and completes
    for (int i = 0; i < DEPTH; i++) wr(i, 8'h10 + i, i % 2, i % 2, 0);
    go();
    idle(2);
    wraps(6, 1);
    idle(2);

    // stop and wrap together in RUN
    go();
    idle(2);
    wraps(1, 0);
    bus.stop     = 1'b1;
    bus.cnt_wrap = 1'b1;
    step();
    idle(2);

    // start+stop in idle, start while busy, wrap while idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.cnt_wrap = 1'b1;
    step();
    go();
    go();
    idle(1);
    go();
    bus.stop = 1'b1;
    step();

    // same-cycle write and load of entry 0 uses old contents
    bus.start = 1'b1;
    step();
    wr(0, 8'h77, 1, 0, 1);
    idle(2);
    wraps(3, 0);
    idle(1);

    // reset mid-run clears table; restart runs zeros
    go();
    idle(3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle(1);
    go();
    idle(2);
    wraps(4, 1);
    idle(2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 2'($urandom_range(0, DEPTH - 1));
        bus.cfg_period = 8'($urandom_range(0, 255));
        bus.cfg_slope  = 1'($urandom_range(0, 1));
        bus.cfg_repeat = 8'($urandom_range(0, 3));
        bus.cfg_last   = ($urandom_range(0, 2) == 0);
      end
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.stop     = ($urandom_range(0, 39) == 0);
      bus.cnt_wrap = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) bus.loop = ~bus.loop;
      step();
    end
    bus.loop = 1'b0;
    idle(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
